imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream boot loader that writes a program image into instruction memory. It drives the write port of instruction memory, which the CPU fetch path only reads.
- It holds the CPU in reset until a complete, checksum-valid image has been written.
- It sits between an external byte source (UART receiver or test bench) and the instruction_memory write_enabled / input_address / input_data pins.

Parameters:
- ADDR_WIDTH, 32, width of the memory byte address.
- BASE_ADDR, 0, byte address of the first loaded word.
- MAX_WORDS, 256, maximum accepted word count; a larger header count is an error.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  incoming stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_write_enabled  out  1  one-cycle write strobe to instruction memory.
- mem_input_address  out  ADDR_WIDTH  byte address of the word being written.
- mem_input_data  out  32  word being written.
- cpu_hold  out  1  CPU/pc reset request; 1 = hold.
- done  out  1  image loaded and verified.
- err_checksum  out  1  checksum mismatch on the last image.
- err_overflow  out  1  header count exceeded MAX_WORDS.
- words_loaded  out  16  words written so far in the current image.

Behaviour:
- Handshake: a byte is consumed on a rising edge only when in_valid && in_ready. in_ready is registered and is 0 in WRITE and in reset, 1 in every other state. Bytes offered while in_ready=0 are not consumed; the source must hold them.
- Frame format: 0xA5 magic, COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first, then a 1-byte checksum. The checksum is the XOR of all 4N payload bytes; it is 0x00 when N=0.
- Reset (reset=0, async) sets: state=IDLE, in_ready=0, mem_write_enabled=0, mem_input_address=BASE_ADDR, mem_input_data=0, cpu_hold=1, done=0, err_checksum=0, err_overflow=0, words_loaded=0, internal count/xor/byte index=0. in_ready rises on the first clock edge after reset deasserts.
- IDLE:
  - Byte 0xA5 -> COUNT_HI. On entry: clear done, err_*, words_loaded and running xor; set cpu_hold=1; set address=BASE_ADDR.
  - Any other byte is discarded; state stays IDLE.
- COUNT_HI: store the high byte -> COUNT_LO.
- COUNT_LO: store the low byte.
  - N > MAX_WORDS -> ERROR with err_overflow=1.
  - N == 0 -> CHECK.
  - Otherwise -> DATA with byte index 0.
- DATA:
  - Shift each byte into the word register (byte 0 lands in [31:24]) and XOR it into the running checksum.
  - On the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - mem_write_enabled=1, mem_input_data=assembled word, mem_input_address = BASE_ADDR + 4*words_loaded.
  - Next cycle: words_loaded+1, address+4. If words_loaded+1 == N -> CHECK, else -> DATA.
  - Latency: the write strobe occurs one cycle after the 4th byte is accepted.
- CHECK:
  - Byte equals the running xor -> DONE: done=1, cpu_hold=0 the next cycle.
  - Otherwise -> ERROR: err_checksum=1, cpu_hold stays 1.
- DONE / ERROR:
  - A 0xA5 byte restarts the load, same as in IDLE (cpu_hold reasserts in the same cycle as state -> COUNT_HI).
  - Any other byte is discarded; flags hold.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is permitted without error.
- words_loaded saturates at MAX_WORDS; it is unreachable beyond that by construction.
- A 0xA5 byte received inside COUNT/DATA/CHECK is ordinary data; there is no resynchronisation mid-frame.
- Reset asserted mid-frame aborts immediately: no further write strobe, cpu_hold=1, the partial image is left in memory, and done=0.
- mem_write_enabled is never asserted outside WRITE.

Test Plan:
1. Single word: stream A5 00 01 20 08 00 05 2D -> one strobe, address 0x0, data 0x20080005. Then done=1, cpu_hold=0, words_loaded=1, err_*=0.
2. Two words, BASE_ADDR=0x100: stream A5 00 02 20 08 00 05 01 09 50 20 then checksum 0x55 -> strobes at 0x100=0x20080005 and 0x104=0x01095020, then done=1.
3. Bad checksum: test 1 with last byte 0x2C -> one write occurs, then err_checksum=1, done=0, cpu_hold=1. A following correct frame clears err_checksum and ends with done=1.
4. Overflow and empty image:
   - MAX_WORDS=4, header A5 01 00 -> err_overflow=1, no strobe, cpu_hold=1.
   - Frame A5 00 00 00 -> done=1 with no strobe.
5. Backpressure and garbage: leading bytes 00 FF before A5 are discarded. in_valid is held high continuously during test 1 -> in_ready=0 exactly in the WRITE cycle, no byte is lost or duplicated, and the data is correct.
6. Reset mid-frame: reset=0 after the 2nd data byte -> outputs return to reset values asynchronously (cpu_hold=1, strobe=0). A subsequent full frame then loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses an A5-framed image, writes it word by word
// into instruction memory and releases the CPU once the checksum matches.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for the 0xA5 magic byte, other bytes dropped
// COUNT_HI | next byte is the high byte of the word count
// COUNT_LO | next byte is the low byte of the word count
// DATA     | collecting the 4 bytes (MSB first) of the next word
// WRITE    | one-cycle write strobe to memory, input stalled
// CHECK    | next byte is the XOR checksum of the payload
// DONE     | image verified, CPU released, 0xA5 restarts a load
// ERROR    | overflow or bad checksum, CPU held, 0xA5 restarts a load
module imem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_write_enabled,
  output logic [ADDR_WIDTH-1:0] mem_input_address,
  output logic [31:0]           mem_input_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err_checksum,
  output logic                  err_overflow,
  output logic [15:0]           words_loaded
);

  localparam logic [7:0]            MAGIC     = 8'hA5;
  localparam logic [15:0]           MAX_N     = 16'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT_HI, S_COUNT_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        is_magic;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [15:0] n_full;
  logic [15:0] wl_inc;
  logic [23:0] word_sr;
  logic [7:0]  xor_acc;
  logic [1:0]  byte_idx;

  assign accept   = in_valid && in_ready;
  assign is_magic = (in_data == MAGIC);
  assign n_full   = {count_hi, in_data};
  assign wl_inc   = words_loaded + 16'd1;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; only WRITE advances without a consumed byte.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (accept && is_magic) state_next = S_COUNT_HI;
      S_COUNT_HI: if (accept) state_next = S_COUNT_LO;
      S_COUNT_LO: begin
        if (accept) begin
          if (n_full > MAX_N)       state_next = S_ERROR;
          else if (n_full == 16'd0) state_next = S_CHECK;
          else                      state_next = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_idx == 2'd3) state_next = S_WRITE;
      S_WRITE: state_next = (wl_inc == count) ? S_CHECK : S_DATA;
      S_CHECK: begin
        if (accept) state_next = (in_data == xor_acc) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered ready: low only while the write strobe is on the bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) in_ready <= 1'b0;
    else        in_ready <= (state_next != S_WRITE);
  end

  // Datapath: word assembly, checksum, memory port and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_write_enabled <= 1'b0;
      mem_input_address <= BASE_ADDR;
      mem_input_data    <= 32'd0;
      cpu_hold          <= 1'b1;
      done              <= 1'b0;
      err_checksum      <= 1'b0;
      err_overflow      <= 1'b0;
      words_loaded      <= 16'd0;
      count_hi          <= 8'd0;
      count             <= 16'd0;
      word_sr           <= 24'd0;
      xor_acc           <= 8'd0;
      byte_idx          <= 2'd0;
    end else begin
      mem_write_enabled <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept && is_magic) begin
            done              <= 1'b0;
            err_checksum      <= 1'b0;
            err_overflow      <= 1'b0;
            words_loaded      <= 16'd0;
            xor_acc           <= 8'd0;
            byte_idx          <= 2'd0;
            cpu_hold          <= 1'b1;
            mem_input_address <= BASE_ADDR;
          end
        end
        S_COUNT_HI: if (accept) count_hi <= in_data;
        S_COUNT_LO: begin
          if (accept) begin
            count    <= n_full;
            byte_idx <= 2'd0;
            if (n_full > MAX_N) err_overflow <= 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            word_sr  <= {word_sr[15:0], in_data};
            xor_acc  <= xor_acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_write_enabled <= 1'b1;
              mem_input_data    <= {word_sr, in_data};
            end
          end
        end
        S_WRITE: begin
          words_loaded      <= (words_loaded == MAX_N) ? words_loaded : wl_inc;
          mem_input_address <= mem_input_address + ADDR_STEP;
        end
        S_CHECK: begin
          if (accept) begin
            if (in_data == xor_acc) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err_checksum <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are
// driven and popped when the write strobe is observed.
module tb_imem_loader;

  localparam int          AW      = 32;
  localparam logic [31:0] TB_BASE = 32'h100;
  localparam int          TB_MAX  = 4;

  logic          clock;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_write_enabled;
  logic [AW-1:0] mem_input_address;
  logic [31:0]   mem_input_data;
  logic          cpu_hold;
  logic          done;
  logic          err_checksum;
  logic          err_overflow;
  logic [15:0]   words_loaded;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (TB_BASE),
    .MAX_WORDS (TB_MAX)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .mem_write_enabled(mem_write_enabled),
    .mem_input_address(mem_input_address),
    .mem_input_data   (mem_input_data),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .err_checksum     (err_checksum),
    .err_overflow     (err_overflow),
    .words_loaded     (words_loaded)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          stalls   = 0;
  logic [31:0] img[8];

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and score any write strobe against the queue.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (mem_write_enabled !== 1'b0) begin
      chk("strobe_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("write_addr", mem_input_address, e.addr);
        chk("write_data", mem_input_data, e.data);
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Offer one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      acc = (in_ready === 1'b1);
      if (!acc) begin
        stalls++;
        chk("stall_only_in_write", {31'b0, mem_write_enabled}, 32'd1);
      end
      tick();
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  // Header count n, send nsend words from img; checksum sent only for a full frame.
  task automatic send_frame(input int n, input int nsend, input bit corrupt);
    logic [7:0]  ck;
    logic [7:0]  bt;
    logic [15:0] n16;
    n16 = 16'(n);
    ck  = 8'h00;
    send_byte(8'hA5);
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    for (int i = 0; i < nsend; i++) begin
      for (int b = 0; b < 4; b++) begin
        bt = img[i][31-8*b -: 8];
        ck = ck ^ bt;
        if (b == 3) sb.push_back('{addr: TB_BASE + 32'(4 * i), data: img[i]});
        send_byte(bt);
        if (b == 3) chk("write_latency", 32'(sb.size()), 32'd0);
      end
    end
    if (nsend == n) send_byte(corrupt ? (ck ^ 8'h01) : ck);
    in_valid = 1'b0;
  endtask

  task automatic status(input string tag, input logic e_done, input logic e_hold,
                        input logic e_ck, input logic e_ov, input int e_wl,
                        input logic [31:0] e_addr);
    chk({tag, "_done"}, {31'b0, done}, {31'b0, e_done});
    chk({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, e_hold});
    chk({tag, "_err_checksum"}, {31'b0, err_checksum}, {31'b0, e_ck});
    chk({tag, "_err_overflow"}, {31'b0, err_overflow}, {31'b0, e_ov});
    chk({tag, "_words_loaded"}, {16'b0, words_loaded}, 32'(e_wl));
    chk({tag, "_address"}, mem_input_address, e_addr);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_strobe", {31'b0, mem_write_enabled}, 32'd0);
    chk("rst_data", mem_input_data, 32'd0);
    status("rst", 1'b0, 1'b1, 1'b0, 1'b0, 0, TB_BASE);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Garbage then a single-word frame with in_valid held high throughout.
    img[0] = 32'h20080005;
    img[1] = 32'h01095020;
    stalls = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("garbage_no_done", {31'b0, done}, 32'd0);
    send_frame(1, 1, 1'b0);
    chk("stalls_one_word", 32'(stalls), 32'd1);
    idle(2);
    status("single", 1'b1, 1'b0, 1'b0, 1'b0, 1, TB_BASE + 32'd4);

    // Two-word frame.
    stalls = 0;
    send_frame(2, 2, 1'b0);
    chk("stalls_two_words", 32'(stalls), 32'd2);
    idle(2);
    status("two", 1'b1, 1'b0, 1'b0, 1'b0, 2, TB_BASE + 32'd8);

    // Bad checksum, then recovery.
    send_frame(1, 1, 1'b1);
    idle(2);
    status("badck", 1'b0, 1'b1, 1'b1, 1'b0, 1, TB_BASE + 32'd4);
    send_frame(1, 1, 1'b0);
    idle(2);
    status("recover", 1'b1, 1'b0, 1'b0, 1'b0, 1, TB_BASE + 32'd4);

    // Overflow one above the limit; stray byte in ERROR is ignored.
    send_frame(TB_MAX + 1, 0, 1'b0);
    idle(2);
    status("overflow", 1'b0, 1'b1, 1'b0, 1'b1, 0, TB_BASE);
    send_byte(8'h00);
    idle(2);
    status("err_hold", 1'b0, 1'b1, 1'b0, 1'b1, 0, TB_BASE);

    // Exactly the limit is accepted.
    img[2] = 32'hDEADBEEF;
    img[3] = 32'hA5A5_0F0F;
    send_frame(TB_MAX, TB_MAX, 1'b0);
    idle(2);
    status("at_max", 1'b1, 1'b0, 1'b0, 1'b0, TB_MAX, TB_BASE + 32'(4 * TB_MAX));

    // Empty image.
    send_frame(0, 0, 1'b0);
    idle(2);
    status("empty", 1'b1, 1'b0, 1'b0, 1'b0, 0, TB_BASE);

    // Reset mid-frame: one word written, two bytes of the second word sent.
    img[0] = 32'h20080005;
    img[1] = 32'h01095020;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    sb.push_back('{addr: TB_BASE, data: img[0]});
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h09);
    in_valid = 1'b0;
    chk("pre_reset_words", {16'b0, words_loaded}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_strobe", {31'b0, mem_write_enabled}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
    status("async_rst", 1'b0, 1'b1, 1'b0, 1'b0, 0, TB_BASE);
    @(negedge clock);
    reset = 1'b1;
    tick();
    send_frame(2, 2, 1'b0);
    idle(2);
    status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2, TB_BASE + 32'd8);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
